// File: rtl/pipeline_stall_unit.sv
// Stall/flush control for the five-stage pipeline with saturating counters.
// Ports:
//   CLK, RST
//   ihit, dhit, exm_dmemREN/WEN, exm_branch_taken, idex_memread,
//   idex_rt_out, ifid_rs, ifid_rt, mwb_halt
//   pc_en, {ifid,idex,exm}_en, {ifid,idex,exm}_flush, mwb_en, halt,
//   cycle_cnt, bubble_cnt, flush_cnt, freeze_cnt
module pipeline_stall_unit #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exm_dmemREN,
   input  logic             exm_dmemWEN,
   input  logic             exm_branch_taken,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt_out,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             mwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exm_en,
   output logic             exm_flush,
   output logic             mwb_en,
   output logic             halt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FREEZE = 2'd1,
      HALTED = 2'd2
   } stateT;

   stateT state;
   stateT stateNext;
   logic  haltQ;

   logic dmemBusy;
   logic advance;
   logic loadUse;
   logic isHalted;

   // one-hot case selects, priority already folded in
   logic selHold;
   logic selBranch;
   logic selLu;

   assign dmemBusy = (exm_dmemREN | exm_dmemWEN) & ~dhit;
   assign advance  = ihit & ~dmemBusy;
   assign isHalted = (state == HALTED);

   // r0 is never a real dependency
   assign loadUse = idex_memread
                  & (idex_rt_out != 5'd0)
                  & ((idex_rt_out == ifid_rs) | (idex_rt_out == ifid_rt));

   assign selHold   = RST | isHalted | ~advance;
   assign selBranch = ~selHold & exm_branch_taken;
   assign selLu     = ~selHold & ~exm_branch_taken & loadUse;

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exm_en     = 1'b0;
      exm_flush  = 1'b0;
      mwb_en     = 1'b0;
      unique case (1'b1)
         selHold: begin
            pc_en = 1'b0;
         end
         selBranch: begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exm_en     = 1'b1;
            exm_flush  = 1'b1;
            mwb_en     = 1'b1;
         end
         selLu: begin
            // hold PC and IF/ID, inject a bubble into ID/EX
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exm_en     = 1'b1;
            mwb_en     = 1'b1;
         end
         default: begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
            exm_en  = 1'b1;
            mwb_en  = 1'b1;
         end
      endcase
   end

   always_comb begin
      stateNext = state;
      if (!isHalted) begin
         if (mwb_halt & advance) begin
            stateNext = HALTED;
         end else if (!advance) begin
            stateNext = FREEZE;
         end else begin
            stateNext = RUN;
         end
      end
   end

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= RUN;
         haltQ      <= 1'b0;
         cycle_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         state <= stateNext;
         haltQ <= (stateNext == HALTED);
         if (!isHalted) begin
            cycle_cnt <= satInc(cycle_cnt);
         end
         if (selLu) begin
            bubble_cnt <= satInc(bubble_cnt);
         end
         if (selBranch) begin
            flush_cnt <= satInc(flush_cnt);
         end
         // count freeze events, not frozen cycles
         if ((state == RUN) && (stateNext == FREEZE)) begin
            freeze_cnt <= satInc(freeze_cnt);
         end
      end
   end

   assign halt = haltQ;

endmodule
